// File: rtl/pfclk_ctrl_pkg.sv
// pfclk_ctrl_pkg: state encodings and shared widths for the PF clock TX bring-up sequencer
package pfclk_ctrl_pkg;
  localparam int RETRY_W    = 4;
  localparam int LOCKLOSS_W = 16;
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CPLL_RST  = 3'd1,
    ST_WAIT_LOCK = 3'd2,
    ST_GT_RST    = 3'd3,
    ST_WAIT_DONE = 3'd4,
    ST_SETTLE    = 3'd5,
    ST_RUN       = 3'd6,
    ST_FAULT     = 3'd7
  } state_e;
endpackage

// File: rtl/pfclk_sync2.sv
// pfclk_sync2: 2-FF synchroniser bringing asynchronous status pins into clk_125
module pfclk_sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk_125,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] sync_q
);
  logic [WIDTH-1:0] meta_q;
  // two-stage shift; status reads as deasserted while in reset
  always_ff @(posedge clk_125) begin
    if (!reset_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_in;
      sync_q <= meta_q;
    end
  end
endmodule

// File: rtl/pfclk_tx_seq_ctrl.sv
// pfclk_tx_seq_ctrl: GTX TX reset/bring-up sequencer; PFCLK_LOCKLOSS_CNT_EN adds the lockloss_cnt port
module pfclk_tx_seq_ctrl
  import pfclk_ctrl_pkg::*;
#(
  parameter int RST_PULSE = 16,
  parameter int LOCK_TMO  = 65535,
  parameter int DONE_TMO  = 65535,
  parameter int SETTLE    = 256,
  parameter int MAX_RETRY = 7,
  parameter int CNT_W     = 17
) (
  input  logic               clk_125,
  input  logic               reset_n,
  input  logic               enable,
  input  logic               clear_fault,
  input  logic               cpll_lock_in,
  input  logic               pll_lock_in,
  input  logic               reset_done_in,
  output logic               cpll_reset_out,
  output logic               gt_soft_reset_out,
  output logic               data_valid_out,
  output logic               link_up,
  output logic               fault,
  output logic [RETRY_W-1:0] retry_cnt,
  output logic [2:0]         state_o
`ifdef PFCLK_LOCKLOSS_CNT_EN
  ,
  output logic [LOCKLOSS_W-1:0] lockloss_cnt
`endif
);
  logic [2:0]         sync_q;
  state_e             state_q, state_d;
  logic [CNT_W-1:0]   timer_q, timer_d;
  logic [RETRY_W-1:0] retry_q, retry_d, retry_inc;
  logic cpll_reset_q, cpll_reset_d, gt_reset_q, gt_reset_d;
  logic dv_q, dv_d, link_q, link_d, fault_q, fault_d;
  logic fail, locked, all_ok;

  pfclk_sync2 #(.WIDTH(3)) u_sync (
    .clk_125 (clk_125),
    .reset_n (reset_n),
    .d_in    ({reset_done_in, pll_lock_in, cpll_lock_in}),
    .sync_q  (sync_q)
  );

  assign locked    = sync_q[0] & sync_q[1];
  assign all_ok    = &sync_q;
  assign retry_inc = &retry_q ? retry_q : retry_q + 1'b1;

  // next state, shared timer and retry bookkeeping; outputs are decoded from the next state so they register in step with it
  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    fail    = 1'b0;
    if (!enable && state_q != ST_FAULT) state_d = ST_IDLE;
    else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_CPLL_RST;
          retry_d = '0;
        end
        ST_CPLL_RST:  state_d = timer_q == CNT_W'(RST_PULSE - 1) ? ST_WAIT_LOCK : state_q;
        ST_WAIT_LOCK: if (locked) state_d = ST_GT_RST;
                      else fail = timer_q == CNT_W'(LOCK_TMO - 1);
        ST_GT_RST:    state_d = timer_q == CNT_W'(RST_PULSE - 1) ? ST_WAIT_DONE : state_q;
        ST_WAIT_DONE: if (sync_q[2]) state_d = ST_SETTLE;
                      else fail = timer_q == CNT_W'(DONE_TMO - 1);
        ST_SETTLE: begin
          fail = !all_ok;
          if (all_ok && timer_q == CNT_W'(SETTLE - 1)) begin
            state_d = ST_RUN;
            retry_d = '0;
          end
        end
        ST_RUN: begin
          retry_d = '0;
          if (!all_ok) state_d = ST_CPLL_RST;
        end
        default: if (clear_fault) begin
          state_d = ST_IDLE;
          retry_d = '0;
        end
      endcase
    end
    if (fail) begin
      retry_d = retry_inc;
      state_d = retry_inc > RETRY_W'(MAX_RETRY) ? ST_FAULT : ST_CPLL_RST;
    end
    timer_d      = state_d != state_q ? '0 : (&timer_q ? timer_q : timer_q + 1'b1);
    cpll_reset_d = state_d inside {ST_IDLE, ST_CPLL_RST, ST_FAULT};
    gt_reset_d   = state_d inside {ST_IDLE, ST_CPLL_RST, ST_WAIT_LOCK, ST_GT_RST, ST_FAULT};
    dv_d         = state_d inside {ST_SETTLE, ST_RUN};
    link_d       = state_d == ST_RUN;
    fault_d      = state_d == ST_FAULT;
  end

  // state, timer, retry counter and output registers
  always_ff @(posedge clk_125) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      timer_q      <= '0;
      retry_q      <= '0;
      cpll_reset_q <= 1'b1;
      gt_reset_q   <= 1'b1;
      dv_q         <= 1'b0;
      link_q       <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      retry_q      <= retry_d;
      cpll_reset_q <= cpll_reset_d;
      gt_reset_q   <= gt_reset_d;
      dv_q         <= dv_d;
      link_q       <= link_d;
      fault_q      <= fault_d;
    end
  end

  assign cpll_reset_out    = cpll_reset_q;
  assign gt_soft_reset_out = gt_reset_q;
  assign data_valid_out    = dv_q;
  assign link_up           = link_q;
  assign fault             = fault_q;
  assign retry_cnt         = retry_q;
  assign state_o           = state_q;

`ifdef PFCLK_LOCKLOSS_CNT_EN
  logic [LOCKLOSS_W-1:0] lockloss_q, lockloss_d;
  // count RUN exits caused by lock/done loss; only reset_n clears it
  always_comb lockloss_d = (state_q == ST_RUN && state_d == ST_CPLL_RST && !(&lockloss_q)) ? lockloss_q + 1'b1 : lockloss_q;
  // lock-loss counter register
  always_ff @(posedge clk_125) lockloss_q <= !reset_n ? '0 : lockloss_d;
  assign lockloss_cnt = lockloss_q;
`endif
endmodule

// File: tb/tb_pfclk_tx_seq_ctrl.sv
// tb_pfclk_tx_seq_ctrl: directed and random bring-up scenarios checked against a behavioural sequencer model
module tb_pfclk_tx_seq_ctrl;
  localparam int RP = 4, LT = 20, DT = 20, ST = 8, MR = 2;
  localparam int P_IDLE = 0, P_CPLL = 1, P_WL = 2, P_GT = 3, P_WD = 4, P_SET = 5, P_RUN = 6, P_FAULT = 7;

  logic clk_125 = 1'b0;
  always #5 clk_125 = ~clk_125;

  logic reset_n, enable, clear_fault, cpll_lock_in, pll_lock_in, reset_done_in;
  logic cpll_reset_out, gt_soft_reset_out, data_valid_out, link_up, fault;
  logic [3:0] retry_cnt;
  logic [2:0] state_o;
`ifdef PFCLK_LOCKLOSS_CNT_EN
  logic [15:0] lockloss_cnt;
`endif

  pfclk_tx_seq_ctrl #(
    .RST_PULSE(RP), .LOCK_TMO(LT), .DONE_TMO(DT), .SETTLE(ST), .MAX_RETRY(MR), .CNT_W(17)
  ) dut (
    .clk_125           (clk_125),
    .reset_n           (reset_n),
    .enable            (enable),
    .clear_fault       (clear_fault),
    .cpll_lock_in      (cpll_lock_in),
    .pll_lock_in       (pll_lock_in),
    .reset_done_in     (reset_done_in),
    .cpll_reset_out    (cpll_reset_out),
    .gt_soft_reset_out (gt_soft_reset_out),
    .data_valid_out    (data_valid_out),
    .link_up           (link_up),
    .fault             (fault),
    .retry_cnt         (retry_cnt),
    .state_o           (state_o)
`ifdef PFCLK_LOCKLOSS_CNT_EN
    ,
    .lockloss_cnt      (lockloss_cnt)
`endif
  );

  int n_vec = 0, n_err = 0;
  int m_st = P_IDLE, m_t = 0, m_rc = 0, m_ll = 0;
  logic [2:0] h0 = '0, h1 = '0;
  bit auto_m = 1'b1;
  int lock_dly = 5, done_dly = 3, lk_cnt = 0, dn_cnt = 0;
  logic [2:0] drop = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit f_cpll(input int s); return s == P_IDLE || s == P_CPLL || s == P_FAULT; endfunction
  function automatic bit f_gt(input int s); return s <= P_GT || s == P_FAULT; endfunction

  task automatic model_step();
    logic [2:0] seen;
    int nx;
    bit bad;
    seen = h1;
    h1 = h0;
    h0 = {reset_done_in, pll_lock_in, cpll_lock_in};
    if (!reset_n) begin
      m_st = P_IDLE; m_t = 0; m_rc = 0; m_ll = 0; h0 = '0; h1 = '0;
      return;
    end
    nx = m_st;
    bad = 1'b0;
    if (!enable && m_st != P_FAULT) nx = P_IDLE;
    else if (m_st == P_IDLE) begin nx = P_CPLL; m_rc = 0; end
    else if (m_st == P_CPLL) nx = (m_t + 1 == RP) ? P_WL : m_st;
    else if (m_st == P_WL) begin
      if (seen[0] && seen[1]) nx = P_GT; else bad = (m_t + 1 == LT);
    end
    else if (m_st == P_GT) nx = (m_t + 1 == RP) ? P_WD : m_st;
    else if (m_st == P_WD) begin
      if (seen[2]) nx = P_SET; else bad = (m_t + 1 == DT);
    end
    else if (m_st == P_SET) begin
      if (seen != 3'b111) bad = 1'b1;
      else if (m_t + 1 == ST) begin nx = P_RUN; m_rc = 0; end
    end
    else if (m_st == P_RUN) begin
      if (seen != 3'b111) begin nx = P_CPLL; if (m_ll < 65535) m_ll++; end
    end
    else if (clear_fault) begin nx = P_IDLE; m_rc = 0; end
    if (bad) begin
      if (m_rc < 15) m_rc++;
      nx = (m_rc > MR) ? P_FAULT : P_CPLL;
    end
    m_t = (nx == m_st) ? m_t + 1 : 0;
    m_st = nx;
  endtask

  task automatic check_all();
    chk("state", 32'(state_o), m_st);
    chk("cpll_reset", 32'(cpll_reset_out), 32'(f_cpll(m_st)));
    chk("gt_reset", 32'(gt_soft_reset_out), 32'(f_gt(m_st)));
    chk("data_valid", 32'(data_valid_out), 32'(m_st == P_SET || m_st == P_RUN));
    chk("link_up", 32'(link_up), 32'(m_st == P_RUN));
    chk("fault", 32'(fault), 32'(m_st == P_FAULT));
    chk("retry_cnt", 32'(retry_cnt), m_rc);
`ifdef PFCLK_LOCKLOSS_CNT_EN
    chk("lockloss_cnt", 32'(lockloss_cnt), m_ll);
`endif
  endtask

  task automatic tick();
    if (auto_m) begin
      cpll_lock_in  = (lk_cnt >= lock_dly) && !drop[0];
      pll_lock_in   = (lk_cnt >= lock_dly) && !drop[1];
      reset_done_in = (dn_cnt >= done_dly) && !drop[2];
    end
    @(posedge clk_125);
    model_step();
    @(negedge clk_125);
    check_all();
    lk_cnt = f_cpll(m_st) ? 0 : lk_cnt + 1;
    dn_cnt = f_gt(m_st) ? 0 : dn_cnt + 1;
    drop = '0;
  endtask

  task automatic wait_st(input string tag, input int s, input int budget);
    int n = 0;
    while (m_st != s && n < budget) begin tick(); n++; end
    chk(tag, 32'(m_st), s);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset_n = 1'b0; enable = 1'b0; clear_fault = 1'b0;
    cpll_lock_in = 1'b0; pll_lock_in = 1'b0; reset_done_in = 1'b0;
    repeat (3) tick();
    chk("rst_cpll", 32'(cpll_reset_out), 1);
    chk("rst_gt", 32'(gt_soft_reset_out), 1);
    chk("rst_state", 32'(state_o), 0);
    reset_n = 1'b1;
    repeat (2) tick();
    enable = 1'b1;
    wait_st("bringup_run", P_RUN, 100);
    chk("bringup_link", 32'(link_up), 1);
    chk("bringup_rc", 32'(retry_cnt), 0);
    repeat (5) tick();
    drop = 3'b010;
    tick();
    wait_st("lockloss_cpll", P_CPLL, 5);
    chk("lockloss_link", 32'(link_up), 0);
    chk("lockloss_rc", 32'(retry_cnt), 0);
    wait_st("lockloss_run", P_RUN, 100);
`ifdef PFCLK_LOCKLOSS_CNT_EN
    chk("lockloss_cnt1", 32'(lockloss_cnt), 1);
`endif
    enable = 1'b0;
    tick();
    enable = 1'b1;
    wait_st("glitch_settle", P_SET, 100);
    repeat (4) tick();
    drop = 3'b100;
    tick();
    wait_st("glitch_cpll", P_CPLL, 5);
    chk("glitch_rc", 32'(retry_cnt), 1);
    wait_st("glitch_run", P_RUN, 100);
    lock_dly = 1000;
    enable = 1'b0;
    tick();
    enable = 1'b1;
    wait_st("tmo_fault", P_FAULT, 200);
    chk("tmo_rc", 32'(retry_cnt), 3);
    chk("tmo_fault_o", 32'(fault), 1);
    chk("tmo_cpll", 32'(cpll_reset_out), 1);
    chk("tmo_gt", 32'(gt_soft_reset_out), 1);
    repeat (3) tick();
    clear_fault = 1'b1;
    tick();
    clear_fault = 1'b0;
    chk("clr_state", 32'(state_o), 0);
    chk("clr_rc", 32'(retry_cnt), 0);
    n = 0;
    while (!(m_st == P_WL && m_rc == 1 && m_t == LT - 1) && n < 200) begin tick(); n++; end
    chk("pri_reach", 32'(n < 200), 1);
    enable = 1'b0;
    tick();
    chk("pri_state", 32'(state_o), 0);
    chk("pri_rc", 32'(retry_cnt), 1);
    auto_m = 1'b0;
    cpll_lock_in = 1'b0; pll_lock_in = 1'b0; reset_done_in = 1'b0;
    enable = 1'b1;
    n = 0;
    while (!(m_st == P_WL && m_t == LT - 3) && n < 100) begin tick(); n++; end
    chk("tie_reach", 32'(n < 100), 1);
    cpll_lock_in = 1'b1; pll_lock_in = 1'b1;
    repeat (3) tick();
    chk("tie_state", 32'(state_o), 3);
    chk("tie_rc", 32'(retry_cnt), 0);
    wait_st("rst_wd", P_WD, 20);
    repeat (2) tick();
    reset_n = 1'b0;
    tick();
    chk("rstwd_state", 32'(state_o), 0);
    chk("rstwd_cpll", 32'(cpll_reset_out), 1);
    chk("rstwd_gt", 32'(gt_soft_reset_out), 1);
    chk("rstwd_dv", 32'(data_valid_out), 0);
    reset_n = 1'b1;
    auto_m = 1'b1;
    lock_dly = 5;
    done_dly = 3;
    for (int i = 0; i < 3000; i++) begin
      enable      = $urandom_range(0, 199) != 0;
      reset_n     = $urandom_range(0, 999) != 0;
      clear_fault = $urandom_range(0, 19) == 0;
      if ($urandom_range(0, 99) == 0) lock_dly = $urandom_range(0, 30);
      if ($urandom_range(0, 99) == 0) done_dly = $urandom_range(0, 30);
      drop = {$urandom_range(0, 49) == 0, $urandom_range(0, 49) == 0, $urandom_range(0, 49) == 0};
      tick();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
